// File: rtl/control_register_pkg.sv
// rtl/control_register_pkg.sv - shared offset-kind enum and map-size helper for the register bank
package control_register_pkg;

    // Which register class a decoded word offset falls into.
    typedef enum logic [1:0] {
        CTRL = 2'd0,
        STAT = 2'd1,
        MASK = 2'd2,
        NONE = 2'd3
    } offset_kind_e;

    // Number of words occupied by the bank: control block, status block, then one mask per status.
    function automatic int unsigned map_words(input int unsigned num_ctrl,
                                              input int unsigned num_stat);
        return num_ctrl + 2 * num_stat;
    endfunction

endpackage

// File: rtl/strobe_register.sv
// rtl/strobe_register.sv - byte-strobed read/write storage register
//
// Purpose: one DATA_WIDTH register whose bytes are written independently.
// Ports:
//   i_clock        - clock, rising edge
//   i_reset        - synchronous active-high reset, loads RESET_VALUE
//   i_write_enable - write this register on this edge
//   i_write_strobe - per-byte enables, bit b covers bits [8b+7:8b]
//   i_write_data   - write payload
//   o_q            - current contents
module strobe_register #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_write_enable,
    input  logic [DATA_WIDTH/8-1:0] i_write_strobe,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    output logic [DATA_WIDTH-1:0]   o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_q <= RESET_VALUE;
        end else if (i_write_enable) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (i_write_strobe[b]) begin
                    r_q[b*8 +: 8] <= i_write_data[b*8 +: 8];
                end
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/control_register_bank.sv
// rtl/control_register_bank.sv - control, W1C status and interrupt-mask register bank
//
// Purpose: bus-accessible bank of NUM_CTRL read/write control registers,
// NUM_STAT write-1-to-clear status registers set by hardware events, and one
// interrupt mask per status register driving a registered irq.
// Ports:
//   clock, reset                 - clock and synchronous active-high reset
//   address                      - byte address of the access
//   write_enable/_data/_strobe   - single-cycle byte-strobed write
//   read_enable                  - single-cycle read request
//   read_data, read_valid        - registered read response, one cycle after request
//   access_error                 - pulse one cycle after an unmapped access
//   ctrl_out                     - packed control registers, register 0 in the LSBs
//   stat_event                   - packed per-bit status set pulses
//   irq                          - registered OR of (status AND mask)
module control_register_bank
    import control_register_pkg::*;
#(
    parameter int                              ADDR_WIDTH = 32,
    parameter int                              DATA_WIDTH = 32,
    parameter int                              NUM_CTRL   = 4,
    parameter int                              NUM_STAT   = 2,
    parameter logic [ADDR_WIDTH-1:0]           BASE_ADDR  = '0,
    parameter logic [NUM_CTRL*DATA_WIDTH-1:0]  CTRL_RESET = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          address,
    input  logic                           write_enable,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [DATA_WIDTH/8-1:0]        write_strobe,
    input  logic                           read_enable,
    output logic [DATA_WIDTH-1:0]          read_data,
    output logic                           read_valid,
    output logic                           access_error,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_event,
    output logic                           irq
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SHIFT     = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int MAP_WORDS = int'(map_words(NUM_CTRL, NUM_STAT));

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_delta;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_aligned;
    logic                  w_mapped;
    offset_kind_e          w_kind;

    // Addresses below BASE_ADDR wrap to huge offsets and fall outside the map.
    assign w_delta   = address - BASE_ADDR;
    assign w_aligned = (w_delta & ADDR_WIDTH'(BYTES - 1)) == '0;
    assign w_offset  = w_delta >> SHIFT;

    always_comb begin
        w_kind  = NONE;
        w_index = '0;
        if (w_aligned) begin
            if (w_offset < ADDR_WIDTH'(NUM_CTRL)) begin
                w_kind  = CTRL;
                w_index = w_offset;
            end else if (w_offset < ADDR_WIDTH'(NUM_CTRL + NUM_STAT)) begin
                w_kind  = STAT;
                w_index = w_offset - ADDR_WIDTH'(NUM_CTRL);
            end else if (w_offset < ADDR_WIDTH'(MAP_WORDS)) begin
                w_kind  = MASK;
                w_index = w_offset - ADDR_WIDTH'(NUM_CTRL + NUM_STAT);
            end
        end
    end

    assign w_mapped = (w_kind != NONE);

    // Byte strobes widened to a bit mask, used for W1C clears.
    logic [DATA_WIDTH-1:0] w_strobe_bits;
    always_comb begin
        w_strobe_bits = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_strobe_bits[b*8 +: 8] = {8{write_strobe[b]}};
        end
    end

    // ------------------------------------------------------------------
    // Control and mask storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_ctrl_q [NUM_CTRL];
    logic [DATA_WIDTH-1:0] w_mask_q [NUM_STAT];

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
        logic w_we;
        assign w_we = write_enable && (w_kind == CTRL) && (w_index == ADDR_WIDTH'(g));

        strobe_register #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (CTRL_RESET[g*DATA_WIDTH +: DATA_WIDTH])
        ) u_ctrl (
            .i_clock        (clock),
            .i_reset        (reset),
            .i_write_enable (w_we),
            .i_write_strobe (write_strobe),
            .i_write_data   (write_data),
            .o_q            (w_ctrl_q[g])
        );

        assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = w_ctrl_q[g];
    end

    for (genvar g = 0; g < NUM_STAT; g++) begin : g_mask
        logic w_we;
        assign w_we = write_enable && (w_kind == MASK) && (w_index == ADDR_WIDTH'(g));

        strobe_register #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE ('0)
        ) u_mask (
            .i_clock        (clock),
            .i_reset        (reset),
            .i_write_enable (w_we),
            .i_write_strobe (write_strobe),
            .i_write_data   (write_data),
            .o_q            (w_mask_q[g])
        );
    end

    // ------------------------------------------------------------------
    // Status registers: hardware set wins over a same-cycle W1C clear
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_stat  [NUM_STAT];
    logic [DATA_WIDTH-1:0] w_clear [NUM_STAT];

    always_comb begin
        for (int i = 0; i < NUM_STAT; i++) begin
            w_clear[i] = '0;
            if (write_enable && (w_kind == STAT) && (w_index == ADDR_WIDTH'(i))) begin
                w_clear[i] = write_data & w_strobe_bits;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_STAT; i++) begin
            if (reset) begin
                r_stat[i] <= '0;
            end else begin
                r_stat[i] <= (r_stat[i] & ~w_clear[i]) | stat_event[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path and responses
    // ------------------------------------------------------------------
    // The mux looks at the current register state, so a read colliding with a
    // write to the same register returns the pre-write value.
    logic [DATA_WIDTH-1:0] w_read_mux;
    always_comb begin
        w_read_mux = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if ((w_kind == CTRL) && (w_index == ADDR_WIDTH'(i))) begin
                w_read_mux = w_ctrl_q[i];
            end
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if ((w_kind == STAT) && (w_index == ADDR_WIDTH'(i))) begin
                w_read_mux = r_stat[i];
            end
            if ((w_kind == MASK) && (w_index == ADDR_WIDTH'(i))) begin
                w_read_mux = w_mask_q[i];
            end
        end
    end

    logic w_irq_next;
    always_comb begin
        w_irq_next = 1'b0;
        for (int i = 0; i < NUM_STAT; i++) begin
            w_irq_next = w_irq_next | (|(r_stat[i] & w_mask_q[i]));
        end
    end

    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;
    logic                  r_access_error;
    logic                  r_irq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_data    <= '0;
            r_read_valid   <= 1'b0;
            r_access_error <= 1'b0;
            r_irq          <= 1'b0;
        end else begin
            r_read_valid   <= read_enable;
            r_access_error <= (read_enable || write_enable) && !w_mapped;
            r_irq          <= w_irq_next;
            if (read_enable) begin
                r_read_data <= w_mapped ? w_read_mux : '0;
            end
        end
    end

    // A response already registered when reset rises is masked so the
    // requester never sees a completion for a transaction reset abandoned.
    assign read_data    = r_read_data;
    assign read_valid   = r_read_valid & ~reset;
    assign access_error = r_access_error & ~reset;
    assign irq          = r_irq;

endmodule

// File: doc/control_register_bank.md
CONTROL_REGISTER_BANK -- requirements
Module: control_register_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, bus address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, 32, register width in bits; a multiple of 8.
REQ-003 SHALL have parameter NUM_CTRL, 4, number of read/write control registers (1..16).
REQ-004 SHALL have parameter NUM_STAT, 2, number of write-1-to-clear status registers (1..16).
REQ-005 SHALL have parameter BASE_ADDR, 0, byte address of register 0, aligned to the bank size.
REQ-006 SHALL have parameter CTRL_RESET, all-zero, NUM_CTRL*DATA_WIDTH reset image for the control registers.
REQ-007 SHALL have port clock, input, 1, sole clock; all logic rises on its positive edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port address, input, ADDR_WIDTH, byte address of the access.
REQ-010 SHALL have port write_enable, input, 1, write request, one cycle per write.
REQ-011 SHALL have port write_data, input, DATA_WIDTH, write payload.
REQ-012 SHALL have port write_strobe, input, DATA_WIDTH/8, byte enables for the write.
REQ-013 SHALL have port read_enable, input, 1, read request, one cycle per read.
REQ-014 SHALL have port read_data, output, DATA_WIDTH, registered read result.
REQ-015 SHALL have port read_valid, output, 1, one-cycle pulse qualifying read_data.
REQ-016 SHALL have port access_error, output, 1, one-cycle pulse for an unmapped access.
REQ-017 SHALL have port ctrl_out, output, NUM_CTRL*DATA_WIDTH, control register contents, register 0 in the LSBs.
REQ-018 SHALL have port stat_event, input, NUM_STAT*DATA_WIDTH, per-bit hardware set pulses.
REQ-019 SHALL have port irq, output, 1, registered interrupt request.

Function
REQ-020 SHALL use a word map, offset = (address-BASE_ADDR)/(DATA_WIDTH/8): control registers at 0..NUM_CTRL-1, status at NUM_CTRL..NUM_CTRL+NUM_STAT-1, interrupt masks at NUM_CTRL+NUM_STAT..NUM_CTRL+2*NUM_STAT-1.
REQ-021 SHALL treat any address outside the map, or not word-aligned, as unmapped.
REQ-022 SHALL update a control or mask register on the edge where write_enable is high; only strobed bytes change; ctrl_out reflects the new value on the following cycle.
REQ-023 SHALL clear each status bit written with 1 on a strobed byte; bits written with 0 are unchanged.
REQ-024 SHALL set each status bit whose stat_event bit is high; a set and a W1C clear in the same cycle SHALL leave the bit at 1.
REQ-025 SHALL return the addressed register on read_data with read_valid high exactly one cycle after read_enable.
REQ-026 SHALL return the pre-write contents when read_enable and write_enable hit the same register in the same cycle.
REQ-027 SHALL hold read_data between reads; read_valid SHALL be low in all other cycles.
REQ-028 SHALL ignore an unmapped write; an unmapped read SHALL return all-zero with read_valid high; both SHALL pulse access_error one cycle after the request.
REQ-029 SHALL drive irq high one cycle after any (status AND mask) bit becomes nonzero, and low one cycle after all of them clear.
REQ-030 SHALL support back-to-back accesses every cycle with no stall.

Reset
REQ-031 SHALL, while reset is high at an edge: load control registers from CTRL_RESET; clear status, masks, read_data, read_valid, access_error and irq; ignore bus requests and stat_event.
REQ-032 SHALL drop any read or error response that is in flight when reset is asserted.

Structure
REQ-033 SHALL place the offset-kind enum (CTRL, STAT, MASK, NONE) and the map-size helper function in a shared package named control_register_pkg.
REQ-034 SHALL implement byte-strobed storage in one sub-module, strobe_register, instanced per control and mask register.

Verification
REQ-035 SHALL show that after reset, a read of offset 0 returns CTRL_RESET[31:0] and irq=0.
REQ-036 SHALL show that writing 32'hA5A5A5A5 to offset 1 with write_strobe=4'b0011 reads back 32'h0000A5A5 with read_valid one cycle later.
REQ-037 SHALL show that stat_event bit 3 pulsed on status 0 with mask 0 = 32'h8 sets irq one cycle later; writing 32'h8 to status 0 clears irq.
REQ-038 SHALL show that a status 0 bit 3 event in the same cycle as a W1C of 32'h8 reads back 32'h8.
REQ-039 SHALL show that a read of BASE_ADDR+0x100 returns 0 with access_error=1 and read_valid=1 one cycle later.
REQ-040 SHALL show that asserting reset in the cycle after read_enable suppresses read_valid.
